// File: rtl/div_hilo_if.sv
// Divider-to-writeback result handshake: the divider (master) presents a result with
// div_valid, and the HI/LO stage (slave) accepts it with div_ready.
interface div_hilo_if #(
   parameter int unsigned WIDTH = 32
);
   logic             div_valid;
   logic             div_ready;
   logic [WIDTH-1:0] div_quotient;
   logic [WIDTH-1:0] div_remainder;
   logic             dividend_neg;
   logic             divisor_neg;
   logic             div_by_zero;

   modport master (
      output div_valid, div_quotient, div_remainder, dividend_neg, divisor_neg, div_by_zero,
      input  div_ready
   );

   modport slave (
      input  div_valid, div_quotient, div_remainder, dividend_neg, divisor_neg, div_by_zero,
      output div_ready
   );
endinterface

// File: rtl/div_hilo_writeback.sv
// Sign-corrects divider magnitudes and commits them into HI (remainder) / LO (quotient).
// Optional macro DIV0_TRAP_EN: divide-by-zero raises div0_exc instead of writing HI/LO.
module div_hilo_writeback #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   div_hilo_if.slave        div,
   input  logic             mthi_en,
   input  logic             mtlo_en,
   input  logic [WIDTH-1:0] mt_data,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             hilo_done,
   output logic             div0_exc
);

   typedef enum logic [1:0] {StIdle, StFixup, StCommit} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             dvd_neg_q, dvd_neg_d, dvs_neg_q, dvs_neg_d, dz_q, dz_d;
   logic             busy_q, busy_d, ready_q, ready_d, done_q, done_d, exc_q, exc_d;

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvd_neg_d = dvd_neg_q;
      dvs_neg_d = dvs_neg_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      exc_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mthi_en) hi_d = mt_data;
            if (mtlo_en) lo_d = mt_data;
            if (div.div_valid) begin
               quo_d     = div.div_quotient;
               rem_d     = div.div_remainder;
               dvd_neg_d = div.dividend_neg;
               dvs_neg_d = div.divisor_neg;
               dz_d      = div.div_by_zero;
               state_d   = StFixup;
            end
         end
         StFixup: begin
            quo_d = (dvd_neg_q ^ dvs_neg_q) ? (-quo_q) : quo_q;
            rem_d = dvd_neg_q ? (-rem_q) : rem_q;
`ifdef DIV0_TRAP_EN
            exc_d  = dz_q;
            done_d = !dz_q;
`else
            // Divide-by-zero reports an all-ones quotient.
            if (dz_q) quo_d = '1;
            done_d = 1'b1;
`endif
            state_d = StCommit;
         end
         StCommit: begin
`ifdef DIV0_TRAP_EN
            if (!dz_q) begin
               hi_d = rem_q;
               lo_d = quo_q;
            end
`else
            hi_d = rem_q;
            lo_d = quo_q;
`endif
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      busy_d  = (state_d != StIdle);
      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         hi_q      <= '0;
         lo_q      <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         exc_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvd_neg_q <= dvd_neg_d;
         dvs_neg_q <= dvs_neg_d;
         dz_q      <= dz_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         exc_q     <= exc_d;
      end
   end

   assign hi_out        = hi_q;
   assign lo_out        = lo_q;
   assign busy          = busy_q;
   assign div.div_ready = ready_q;
   assign hilo_done     = done_q;
`ifdef DIV0_TRAP_EN
   assign div0_exc      = exc_q;
`else
   assign div0_exc      = 1'b0;
   logic unused_exc;
   assign unused_exc    = exc_q;
`endif

endmodule

// File: tb/tb_div_hilo_writeback.sv
// Bench for div_hilo_writeback: directed scenarios with literal results, then random traffic
// checked every cycle against a transaction-level model of HI/LO and the 3-cycle occupancy.
module tb_div_hilo_writeback;

`ifdef DIV0_TRAP_EN
   localparam bit Trap = 1'b1;
`else
   localparam bit Trap = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mthi_en, mtlo_en;
   logic [31:0] mt_data, hi_out, lo_out;
   logic        busy, hilo_done, div0_exc;

   div_hilo_if #(.WIDTH(32)) dif ();

   div_hilo_writeback #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .div       (dif.slave),
      .mthi_en   (mthi_en),
      .mtlo_en   (mtlo_en),
      .mt_data   (mt_data),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .busy      (busy),
      .hilo_done (hilo_done),
      .div0_exc  (div0_exc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   bit chk_en   = 1'b0;

   // Model: architectural HI/LO plus number of busy cycles left for the in-flight divide.
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic        p_dz;
   int          m_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      if (reset) begin
         m_hi = '0; m_lo = '0; m_left = 0;
      end else if (m_left == 0) begin
         if (mthi_en) m_hi = mt_data;
         if (mtlo_en) m_lo = mt_data;
         if (dif.div_valid) begin
            p_dz   = dif.div_by_zero;
            p_lo   = (dif.dividend_neg ^ dif.divisor_neg) ? 32'(0 - dif.div_quotient)
                                                         : dif.div_quotient;
            if (p_dz) p_lo = 32'hFFFF_FFFF;
            p_hi   = dif.dividend_neg ? 32'(0 - dif.div_remainder) : dif.div_remainder;
            m_left = 2;
         end
      end else if (m_left == 2) begin
         m_left = 1;
      end else begin
         if (!(Trap && p_dz)) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
         m_left = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (dif.div_valid && dif.div_ready) n_acc++;
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("hi_out",    hi_out,             m_hi);
         check("lo_out",    lo_out,             m_lo);
         check("busy",      32'(busy),          32'(m_left != 0));
         check("div_ready", 32'(dif.div_ready), 32'(m_left == 0));
         check("hilo_done", 32'(hilo_done),     32'(m_left == 1 && !(Trap && p_dz)));
         check("div0_exc",  32'(div0_exc),      32'(m_left == 1 && Trap && p_dz));
      end
   end

   task automatic set_div(input logic [31:0] q, input logic [31:0] r,
                          input logic dn, input logic sn, input logic dz);
      dif.div_valid     = 1'b1;
      dif.div_quotient  = q;
      dif.div_remainder = r;
      dif.dividend_neg  = dn;
      dif.divisor_neg   = sn;
      dif.div_by_zero   = dz;
   endtask

   task automatic run_div(input logic [31:0] q, input logic [31:0] r,
                          input logic dn, input logic sn, input logic dz);
      set_div(q, r, dn, sn, dz);
      step();
      dif.div_valid = 1'b0;
      step();
      step();
   endtask

   initial begin
      reset = 1'b1;
      mthi_en = 1'b0; mtlo_en = 1'b0; mt_data = '0;
      dif.div_valid = 1'b0; dif.div_quotient = '0; dif.div_remainder = '0;
      dif.dividend_neg = 1'b0; dif.divisor_neg = 1'b0; dif.div_by_zero = 1'b0;
      p_dz = 1'b0; p_hi = '0; p_lo = '0;
      step();
      step();
      reset  = 1'b0;
      chk_en = 1'b1;
      check("rst_hi", hi_out, 32'h0);
      check("rst_lo", lo_out, 32'h0);
      check("rst_ready", 32'(dif.div_ready), 32'h1);

      // 7/2 unsigned: ready low for two cycles, done in the commit cycle.
      set_div(32'd3, 32'd1, 1'b0, 1'b0, 1'b0);
      step();
      dif.div_valid = 1'b0;
      check("t1_ready_fixup", 32'(dif.div_ready), 32'h0);
      step();
      check("t1_ready_commit", 32'(dif.div_ready), 32'h0);
      check("t1_done", 32'(hilo_done), 32'h1);
      step();
      check("t1_lo", lo_out, 32'h0000_0003);
      check("t1_hi", hi_out, 32'h0000_0001);
      check("t1_done_off", 32'(hilo_done), 32'h0);

      run_div(32'd3, 32'd1, 1'b1, 1'b0, 1'b0);
      check("neg_dvd_lo", lo_out, 32'hFFFF_FFFD);
      check("neg_dvd_hi", hi_out, 32'hFFFF_FFFF);
      run_div(32'd3, 32'd1, 1'b0, 1'b1, 1'b0);
      check("neg_dvs_lo", lo_out, 32'hFFFF_FFFD);
      check("neg_dvs_hi", hi_out, 32'h0000_0001);

      run_div(32'd0, 32'd5, 1'b0, 1'b0, 1'b1);
      check("div0_lo", lo_out, Trap ? 32'hFFFF_FFFD : 32'hFFFF_FFFF);
      check("div0_hi", hi_out, Trap ? 32'h0000_0001 : 32'h0000_0005);

      run_div(32'h8000_0000, 32'd7, 1'b1, 1'b1, 1'b0);
      check("ovf_lo", lo_out, 32'h8000_0000);
      check("ovf_hi", hi_out, 32'hFFFF_FFF9);

      mthi_en = 1'b1; mt_data = 32'h1234_5678;
      step();
      mthi_en = 1'b0;
      check("mthi", hi_out, 32'h1234_5678);

      // Move while busy must be ignored.
      set_div(32'd3, 32'd1, 1'b0, 1'b0, 1'b0);
      step();
      dif.div_valid = 1'b0;
      mtlo_en = 1'b1; mt_data = 32'hAAAA_5555;
      step();
      step();
      mtlo_en = 1'b0;
      check("mtlo_busy_lo", lo_out, 32'h0000_0003);

      // Reset while in FIXUP discards the result.
      set_div(32'd9, 32'd2, 1'b0, 1'b0, 1'b0);
      step();
      dif.div_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_hi", hi_out, 32'h0);
      check("mid_rst_lo", lo_out, 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_ready", 32'(dif.div_ready), 32'h1);
      step();
      check("mid_rst_done", 32'(hilo_done), 32'h0);

      // Valid held high for six cycles: two acceptances.
      n_acc = 0;
      set_div(32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
      repeat (6) step();
      dif.div_valid = 1'b0;
      check("b2b_accepts", 32'(n_acc), 32'd2);
      check("b2b_lo", lo_out, 32'h1);

      for (int i = 0; i < 400; i++) begin
         dif.div_valid     = ($urandom_range(1) == 1);
         dif.div_quotient  = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
         dif.div_remainder = $urandom;
         dif.dividend_neg  = $urandom_range(1) == 1;
         dif.divisor_neg   = $urandom_range(1) == 1;
         dif.div_by_zero   = ($urandom_range(9) == 0);
         mthi_en           = ($urandom_range(3) == 0);
         mtlo_en           = ($urandom_range(3) == 0);
         mt_data           = $urandom;
         reset             = ($urandom_range(49) == 0);
         step();
      end
      reset = 1'b0;
      dif.div_valid = 1'b0;
      mthi_en = 1'b0;
      mtlo_en = 1'b0;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_hilo_writeback.md
Name: div_hilo_writeback

Overview:
- Stage directly downstream of the ALU non-restoring divider.
- Accepts the divider's unsigned quotient/remainder magnitudes plus operand sign flags.
- Applies signed-division sign correction and commits the results into the architectural HI (remainder) and LO (quotient) registers.
- Also services direct HI/LO moves and exposes HI/LO for reads; a small FSM with a valid/ready handshake back-pressures the divider.

Parameters:
WIDTH, 32, data width of quotient, remainder, HI and LO

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
div_valid  input  1  divider result available this cycle
div_ready  output  1  stage can accept a divider result
div_quotient  input  WIDTH  unsigned quotient magnitude
div_remainder  input  WIDTH  unsigned remainder magnitude
dividend_neg  input  1  original dividend was negative
divisor_neg  input  1  original divisor was negative
div_by_zero  input  1  original divisor was zero
mthi_en  input  1  direct write of mt_data into HI
mtlo_en  input  1  direct write of mt_data into LO
mt_data  input  WIDTH  data for direct HI/LO write
hi_out  output  WIDTH  current HI register
lo_out  output  WIDTH  current LO register
busy  output  1  result in flight; consumers of HI/LO must stall
hilo_done  output  1  one-cycle pulse on the divide commit cycle
div0_exc  output  1  divide-by-zero exception pulse (see Optional Feature)

Behaviour:
- Reset, synchronous, active-high, takes priority over everything:
  - hi_out=0, lo_out=0, busy=0, hilo_done=0, div0_exc=0, FSM=IDLE.
  - Reset asserted mid-operation discards the in-flight result; HI/LO still go to 0.
- FSM states IDLE, FIXUP, COMMIT.
- IDLE:
  - div_ready=1, busy=0.
  - div_valid=1 latches quotient, remainder, both sign flags and div_by_zero, then moves to FIXUP.
- FIXUP:
  - div_ready=0, busy=1.
  - Registers sq = (dividend_neg XOR divisor_neg) ? -q : q.
  - Registers sr = dividend_neg ? -r : r.
  - Negation is two's complement, modulo 2^WIDTH. Moves to COMMIT.
- COMMIT:
  - div_ready=0, busy=1.
  - Writes LO<=sq, HI<=sr and pulses hilo_done=1. Moves to IDLE.
- Latency: result accepted at edge t is visible on hi_out/lo_out after edge t+2. Throughput is one divide per 3 cycles.
- div_valid while div_ready=0 is ignored; the divider must hold its result until the handshake completes.
- Direct writes (mthi_en/mtlo_en):
  - Honoured only in IDLE, taking effect on the next edge; ignored while busy=1.
  - Both may be asserted together.
  - If asserted in the same IDLE cycle as an accepted div_valid, the move applies now and the divide commit overwrites it 2 cycles later.
- Overflow case (magnitude quotient 0x80000000 with equal signs): LO=0x80000000, HI=sr. No flag.
- Divide-by-zero without the feature macro: LO=0xFFFFFFFF, HI=sr (the divider passes the dividend magnitude as the remainder). hilo_done pulses normally.
- hi_out and lo_out are direct register outputs with no combinational bypass.

Optional Feature:
- Macro DIV0_TRAP_EN.
- Defined: when div_by_zero is latched, the COMMIT cycle leaves HI/LO unchanged, pulses div0_exc=1 for one cycle, and hilo_done stays 0.
- Undefined: div0_exc is tied to 0 and divide-by-zero follows the default rule in Behaviour.

Test Plan:
- Reset, then div_valid with q=3, r=1, signs 0/0 -> div_ready drops for 2 cycles; after edge t+2 LO=0x00000003, HI=0x00000001, hilo_done pulses once.
- q=3, r=1, dividend_neg=1, divisor_neg=0 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then q=3, r=1, divisor_neg=1 only (7/-2) -> LO=0xFFFFFFFD, HI=0x00000001.
- mthi_en with mt_data=0x12345678 in IDLE -> HI=0x12345678 next cycle. mtlo_en with mt_data=0xAAAA5555 while busy=1 -> ignored; LO is unchanged apart from the commit.
- div_by_zero=1, r=5:
  - Without DIV0_TRAP_EN -> LO=0xFFFFFFFF, HI=0x00000005.
  - With DIV0_TRAP_EN -> HI/LO unchanged, div0_exc one-cycle pulse, no hilo_done.
- Accept a divide, then assert reset during FIXUP -> HI=LO=0, busy=0, div_ready=1 next cycle, no hilo_done pulse.
- Back-to-back div_valid held high for 6 cycles with q=1, r=0 -> exactly two acceptances, at cycles 0 and 3; LO=1 after each commit.
